// File: rtl/inst_fetch_unit_if.sv
// Fetch unit bundle: instruction-memory request/response, redirect input and decode-side output.
// The master side is the fetch unit; the slave side is the memory/decode environment.
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [5:0]  out_func;

  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc, out_opcode, out_func,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_opcode, out_func,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC, credit-limited word reads, in-order queue to decode.
// Response at edge N is visible on out_* from cycle N+1; stalls on queue+outstanding credit.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_unit_if.master  bus
);
  localparam int PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW  = PW + 1;
  localparam int CW1 = CW + 1;
  localparam int DW  = 16;
  localparam logic [CW:0] QD = CW1'(QDEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   qi_q  [QDEPTH];
  logic [31:0]   qp_q  [QDEPTH];
  logic [31:0]   tag_q [QDEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, trd_q, trd_d, twr_q, twr_d;
  logic [CW-1:0] cnt_q, cnt_d, outs_q, outs_d;
  logic [DW-1:0] drop_q, drop_d;
  logic [CW:0]   credit;
  logic          accept, resp_keep, resp_drop, pop;

  assign credit       = {1'b0, cnt_q} + {1'b0, outs_q};
  assign bus.imem_req  = rst && !bus.redirect && (credit < QD);
  assign bus.imem_addr = pc_q;

  assign accept    = bus.imem_req && bus.imem_gnt;
  assign resp_drop = bus.imem_rvalid && (drop_q != '0);
  assign resp_keep = bus.imem_rvalid && (drop_q == '0);
  assign pop       = (cnt_q != '0) && bus.out_ready;

  assign bus.out_valid  = (cnt_q != '0);
  assign bus.out_inst   = qi_q[rd_q];
  assign bus.out_pc     = qp_q[rd_q];
  assign bus.out_opcode = qi_q[rd_q][31:26];
  assign bus.out_func   = qi_q[rd_q][5:0];

  always_comb begin
    pc_d   = accept ? pc_q + 32'd4 : pc_q;
    rd_d   = pop ? rd_q + PW'(1) : rd_q;
    wr_d   = resp_keep ? wr_q + PW'(1) : wr_q;
    twr_d  = accept ? twr_q + PW'(1) : twr_q;
    trd_d  = resp_keep ? trd_q + PW'(1) : trd_q;
    cnt_d  = cnt_q + CW'(resp_keep) - CW'(pop);
    outs_d = outs_q + CW'(accept) - CW'(resp_keep);
    drop_d = drop_q - DW'(resp_drop);
    // Every request still in flight becomes stale; a response landing now is one of them.
    if (bus.redirect) begin
      pc_d   = bus.redirect_pc & 32'hFFFF_FFFC;
      rd_d   = '0;
      wr_d   = '0;
      twr_d  = '0;
      trd_d  = '0;
      cnt_d  = '0;
      outs_d = '0;
      drop_d = drop_q + DW'(outs_q) - DW'(bus.imem_rvalid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      rd_q   <= '0;
      wr_q   <= '0;
      trd_q  <= '0;
      twr_q  <= '0;
      cnt_q  <= '0;
      outs_q <= '0;
      drop_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        qi_q[i]  <= '0;
        qp_q[i]  <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      trd_q  <= trd_d;
      twr_q  <= twr_d;
      cnt_q  <= cnt_d;
      outs_q <= outs_d;
      drop_q <= drop_d;
      if (accept) tag_q[twr_q] <= pc_q;
      if (resp_keep && !bus.redirect) begin
        qi_q[wr_q] <= bus.imem_rdata;
        qp_q[wr_q] <= tag_q[trd_q];
      end
    end
  end
endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch front end that produces the instruction stream consumed by the control decoder in the pipeline CPU. Holds the PC, issues word reads to instruction memory, buffers returned words in a small in-order queue and presents them (with PC and pre-split opcode/func fields) to the decode stage over a valid/ready handshake. Branch/jump redirects from later stages flush the queue and discard any in-flight memory responses.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; low 2 bits must be 0.
- QDEPTH, 4, fetch queue entries; power of two, 2..16; also the cap on outstanding requests plus queued words.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- imem_req  out  1  request valid to instruction memory.
- imem_addr  out  32  word address (byte address, low 2 bits 0).
- imem_gnt  in  1  memory accepts request this cycle when imem_req && imem_gnt.
- imem_rvalid  in  1  read data valid; responses return in request order, ≥1 cycle after acceptance.
- imem_rdata  in  32  instruction word.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; low 2 bits ignored (treated as 0).
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode consumes when out_valid && out_ready.
- out_inst  out  32  instruction word.
- out_pc  out  32  PC of out_inst.
- out_opcode  out  6  out_inst[31:26].
- out_func  out  6  out_inst[5:0].

## Operation
- State: pc register, queue of {inst, pc} with rd/wr pointers and count, outstanding counter (accepted, not yet returned), drop counter (responses to discard), queue of issue PCs per outstanding request (or pc-tag FIFO, depth QDEPTH).
- imem_req = !redirect && (count + outstanding < QDEPTH) && rst; imem_addr = pc.
- Accept (imem_req && imem_gnt): pc <= pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); outstanding +1; issue PC recorded.
- Response (imem_rvalid): if drop > 0, drop -1 and data discarded; else {imem_rdata, tagged PC} written to queue, outstanding -1. Credit rule guarantees no overflow; overflow is unreachable and not handled.
- Pop (out_valid && out_ready): rd pointer advances. Push and pop in same cycle: count unchanged, legal when full.
- out_valid = count != 0; out_* driven from queue head; out_opcode/out_func are pure slices of out_inst.
- Redirect (cycle with redirect=1): queue emptied (count 0, pointers reset); pc <= {redirect_pc[31:2],2'b00}; drop <= drop + outstanding (including any accepted-this-cycle is impossible: req is low); an imem_rvalid arriving the same cycle counts toward the discard (it is dropped and drop/outstanding net accordingly); outstanding cleared into drop. A pop in the redirect cycle is ignored (queue flushed regardless).
- Back-to-back redirects: last one wins; drop keeps accumulating until all stale responses return.
- Fetch at new PC may issue the cycle after redirect, even while drop > 0.

## Timing
- Reset (rst=0, any time, asynchronous): pc=RESET_PC, queue empty, outstanding=0, drop=0; out_valid=0, out_inst=0, out_pc=0, out_opcode=0, out_func=0, imem_req=0, imem_addr=RESET_PC. Reset mid-transaction discards all state; memory responses after release are not expected by contract.
- First imem_req asserts in the first cycle with rst=1.
- Latency: response at edge N makes out_valid=1 from cycle N+1 (registered queue, no bypass).
- Throughput: one instruction per cycle with single-cycle memory and QDEPTH ≥ 2.
- out_* stable while out_valid && !out_ready (unless redirect or reset).

## Test plan
- Reset release, imem_gnt=1, memory returns 1 cycle later, out_ready=1 -> out_pc 0x0,0x4,0x8,... on consecutive cycles, one per cycle after 2-cycle fill.
- out_ready=0 with memory always granting -> exactly QDEPTH accepts, imem_req drops, queue holds 4 words; release ready -> words emerge in order, no loss/duplication.
- Word 32'h0109_5020 (add) at head -> out_opcode=6'b000000, out_func=6'b100000; 32'h2108_0005 -> opcode 6'b001000.
- Memory latency 3, two requests outstanding, redirect to 32'h0000_0043 -> both stale responses dropped, next out_pc=0x0000_0040 with the word fetched from 0x40.
- Redirect same cycle as imem_rvalid and as a pop -> queue empty next cycle, stale word never appears, drop count correct.
- pc=32'hFFFF_FFF8 -> fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; assert rst=0 mid-burst -> outputs zero immediately, restart at RESET_PC.
